// File: rtl/count_sequence_checker.sv
// Receive-side checker for a free-running up-counter stream.
// Locks after a run of +1 steps, then flags and tallies out-of-sequence words.
module count_sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_count,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int BW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    // Run counters only need to reach one short of their thresholds.
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    logic [1:0]           state;
    logic [1:0]           state_n;
    logic [GW-1:0]        good_run;
    logic [GW-1:0]        good_n;
    logic [BW-1:0]        bad_run;
    logic [BW-1:0]        bad_n;
    logic                 locked_n;
    logic                 pulse_n;
    logic                 err_inc;
    logic                 match;
    logic [WIDTH-1:0]     expected_n;
    logic [ERR_WIDTH-1:0] err_base;
    logic [ERR_WIDTH-1:0] err_n;

    assign match = in_valid && (in_count == expected);

    // Sequence tracking: state transitions and run lengths per sample.
    always_comb begin
        state_n  = state;
        good_n   = good_run;
        bad_n    = bad_run;
        locked_n = locked;
        pulse_n  = 1'b0;
        err_inc  = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
                ACQUIRE: begin
                    if (match) begin
                        if (good_run == LOCK_LAST) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            good_n   = '0;
                            bad_n    = '0;
                        end else begin
                            good_n = good_run + 1'b1;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        err_inc = 1'b1;
                        if (bad_run == LOSS_LAST) begin
                            state_n  = ACQUIRE;
                            locked_n = 1'b0;
                            good_n   = '0;
                            bad_n    = '0;
                        end else begin
                            bad_n = bad_run + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                    good_n   = '0;
                    bad_n    = '0;
                end
            endcase
        end
    end

    // Re-seed from the data on every sample; clear before increment.
    always_comb begin
        expected_n = in_valid ? in_count + WIDTH'(1) : expected;
        err_base   = err_clr ? '0 : err_count;
        err_n      = err_base;
        if (err_inc && (err_base != ERR_MAX)) begin
            err_n = err_base + 1'b1;
        end
    end

    // Register all state and outputs; reset overrides every input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            good_run  <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            expected  <= '0;
        end else begin
            state     <= state_n;
            good_run  <= good_n;
            bad_run   <= bad_n;
            locked    <= locked_n;
            err_pulse <= pulse_n;
            err_count <= err_n;
            expected  <= expected_n;
        end
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: a default instance and a
// second one with a 2-bit error counter share the same stimulus.
module tb_count_sequence_checker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_count;
    logic       err_clr;

    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [3:0] expected;

    logic       s_locked;
    logic       s_err_pulse;
    logic [1:0] s_err_count;
    logic [3:0] s_expected;

    int n_cmp;
    int n_bad;

    logic [3:0] e;
    logic [3:0] m;

    count_sequence_checker #(
        .WIDTH(4), .LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_WIDTH(8)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .expected(expected)
    );

    count_sequence_checker #(
        .WIDTH(4), .LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_WIDTH(2)
    ) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
        .err_clr(err_clr), .locked(s_locked), .err_pulse(s_err_pulse),
        .err_count(s_err_count), .expected(s_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [3:0] c);
        in_valid = v;
        in_count = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_count = 4'd7;
        err_clr  = 1'b0;
        #2;

        // Reset with valid asserted
        step(1'b1, 4'd7);
        step(1'b1, 4'd8);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pulse", 32'(err_pulse), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_expected", 32'(expected), 0);
        chk("rst_small_err", 32'(s_err_count), 0);
        rst = 1'b1;

        // Lock on 5,6,7,8
        step(1'b1, 4'd5);
        chk("seed_expected", 32'(expected), 6);
        chk("seed_locked", 32'(locked), 0);
        step(1'b1, 4'd6);
        chk("acq1_locked", 32'(locked), 0);
        step(1'b1, 4'd7);
        chk("acq2_locked", 32'(locked), 0);
        step(1'b1, 4'd8);
        chk("lock_locked", 32'(locked), 1);
        chk("lock_expected", 32'(expected), 9);
        chk("lock_err", 32'(err_count), 0);
        chk("lock_pulse", 32'(err_pulse), 0);

        // Run up to the wrap point, then 14,15,0,1
        for (int v = 9; v <= 13; v++) step(1'b1, 4'(v));
        chk("run_locked", 32'(locked), 1);
        chk("run_err", 32'(err_count), 0);
        step(1'b1, 4'd14);
        chk("wrap14_pulse", 32'(err_pulse), 0);
        step(1'b1, 4'd15);
        chk("wrap15_pulse", 32'(err_pulse), 0);
        chk("wrap15_expected", 32'(expected), 0);
        step(1'b1, 4'd0);
        chk("wrap0_pulse", 32'(err_pulse), 0);
        step(1'b1, 4'd1);
        chk("wrap1_pulse", 32'(err_pulse), 0);
        chk("wrap_locked", 32'(locked), 1);
        chk("wrap_expected", 32'(expected), 2);

        // Single error: expected 3, feed 9 then 10
        step(1'b1, 4'd2);
        chk("pre_err_expected", 32'(expected), 3);
        step(1'b1, 4'd9);
        chk("single_pulse", 32'(err_pulse), 1);
        chk("single_err", 32'(err_count), 1);
        chk("single_locked", 32'(locked), 1);
        chk("single_expected", 32'(expected), 10);
        step(1'b1, 4'd10);
        chk("single_pulse_off", 32'(err_pulse), 0);
        chk("single_err_hold", 32'(err_count), 1);
        chk("single_locked2", 32'(locked), 1);
        step(1'b0, 4'd4);
        chk("idle_expected", 32'(expected), 11);
        chk("idle_pulse", 32'(err_pulse), 0);
        chk("idle_locked", 32'(locked), 1);

        // Loss of lock on 3,9 then 2, relock on 3,4,5
        step(1'b1, 4'd3);
        chk("loss1_pulse", 32'(err_pulse), 1);
        chk("loss1_err", 32'(err_count), 2);
        chk("loss1_locked", 32'(locked), 1);
        step(1'b1, 4'd9);
        chk("loss2_pulse", 32'(err_pulse), 1);
        chk("loss2_err", 32'(err_count), 3);
        chk("loss2_locked", 32'(locked), 0);
        step(1'b1, 4'd2);
        chk("loss3_pulse", 32'(err_pulse), 0);
        chk("loss3_err", 32'(err_count), 3);
        chk("loss3_expected", 32'(expected), 3);
        step(1'b1, 4'd3);
        step(1'b1, 4'd4);
        chk("reacq_locked", 32'(locked), 0);
        step(1'b1, 4'd5);
        chk("relock_locked", 32'(locked), 1);
        chk("relock_expected", 32'(expected), 6);
        chk("small_err_sat", 32'(s_err_count), 3);

        // Clear, then five locked mismatches each followed by a match
        err_clr = 1'b1;
        step(1'b0, 4'd0);
        err_clr = 1'b0;
        chk("clr_err", 32'(err_count), 0);
        chk("clr_small_err", 32'(s_err_count), 0);
        chk("clr_locked", 32'(locked), 1);
        e = 4'd6;
        for (int k = 0; k < 5; k++) begin
            m = e + 4'd5;
            step(1'b1, m);
            chk("mis_pulse", 32'(err_pulse), 1);
            step(1'b1, m + 4'd1);
            chk("mis_match_pulse", 32'(err_pulse), 0);
            chk("mis_locked", 32'(locked), 1);
            e = m + 4'd2;
        end
        chk("sat_err_main", 32'(err_count), 5);
        chk("sat_err_small", 32'(s_err_count), 3);

        // Clear together with a counted mismatch
        err_clr = 1'b1;
        step(1'b1, e + 4'd5);
        err_clr = 1'b0;
        chk("clrinc_err", 32'(err_count), 1);
        chk("clrinc_small", 32'(s_err_count), 1);
        chk("clrinc_pulse", 32'(err_pulse), 1);
        chk("clrinc_locked", 32'(locked), 1);

        // Reset mid-operation, then re-seed
        rst = 1'b0;
        step(1'b1, 4'd7);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_expected", 32'(expected), 0);
        chk("mid_rst_err", 32'(err_count), 0);
        chk("mid_rst_pulse", 32'(err_pulse), 0);
        rst = 1'b1;
        step(1'b1, 4'd12);
        chk("reseed_expected", 32'(expected), 13);
        chk("reseed_locked", 32'(locked), 0);
        chk("reseed_pulse", 32'(err_pulse), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
